fwd_hazard_ctrl: RTL and testbench

- Generates the select lines that drive the EX-stage operand MUX_2to1 chains. It is the control end of the operand-select interface.
- Shadows destination-register info for the EX, MEM and WB stages in internal pipeline registers.
- Detects load-use hazards (stall) and taken-branch squashes (flush).
- Keeps stall and flush event counters for performance debug.
- Sits beside the ID/EX pipeline register in the static 5-stage pipeline.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 8 +
 rtl/fwd_hazard_ctrl_sel.sv | 24 ++
 rtl/fwd_hazard_ctrl.sv | 100 ++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline constants for the EX operand-select and hazard control.
package fwd_hazard_ctrl_pkg;
  localparam int         REG_AW   = 5;
  localparam int         REG_ZERO = 0;
  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;
endpackage

// File: rtl/fwd_hazard_ctrl_sel.sv
// Per-operand forwarding priority comparator: MEM beats WB, r0 never forwards.
module fwd_sel_cmp #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_we,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_we,
  output logic [1:0]    sel
);
  import fwd_hazard_ctrl_pkg::*;

  logic mem_hit, wb_hit;

  assign mem_hit = mem_we && (mem_rd != AW'(REG_ZERO)) && (mem_rd == src);
  assign wb_hit  = wb_we  && (wb_rd  != AW'(REG_ZERO)) && (wb_rd  == src);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
  end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select, load-use stall and branch flush control beside ID/EX,
// with shadow copies of the EX/MEM/WB destination info and event counters.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  import fwd_hazard_ctrl_pkg::*;

  localparam int NUM_OPS = 2;

  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic              ex_we, ex_mr, mem_we, wb_we;
  logic              load_use, bubble;

  logic [NUM_OPS-1:0][REG_AW-1:0] op_src;
  logic [NUM_OPS-1:0][1:0]        op_sel;

  // Hazard detection; gating on id_valid keeps stale ID addresses out of the result.
  assign load_use = id_valid && ex_mr && (ex_rd != REG_AW'(REG_ZERO)) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign flush    = ex_branch_taken;
  assign stall    = load_use && !ex_branch_taken;
  assign bubble   = stall || flush || !id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs  <= '0;
      ex_rt  <= '0;
      ex_rd  <= '0;
      ex_we  <= 1'b0;
      ex_mr  <= 1'b0;
      mem_rd <= '0;
      mem_we <= 1'b0;
      wb_rd  <= '0;
      wb_we  <= 1'b0;
    end else begin
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
      if (bubble) begin
        ex_rs <= '0;
        ex_rt <= '0;
        ex_rd <= '0;
        ex_we <= 1'b0;
        ex_mr <= 1'b0;
      end else begin
        ex_rs <= id_rs;
        ex_rt <= id_rt;
        ex_rd <= id_rd;
        ex_we <= id_regwrite;
        ex_mr <= id_memread;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign op_src[0] = ex_rs;
  assign op_src[1] = ex_rt;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    fwd_sel_cmp #(.AW(REG_AW)) u_cmp (
      .src    (op_src[g]),
      .mem_rd (mem_rd),
      .mem_we (mem_we),
      .wb_rd  (wb_rd),
      .wb_we  (wb_we),
      .sel    (op_sel[g])
    );
  end

  assign fwd_a_sel = op_sel[0];
  assign fwd_b_sel = op_sel[1];
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench: driver predicts each cycle's outputs from an age-indexed
// history of in-flight instructions; an independent monitor compares them.
module tb_fwd_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rt, id_regwrite, id_memread, ex_branch_taken;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall, flush;
  logic [31:0] stall_cnt, flush_cnt;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .flush(flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] rs, rt, rd; logic we, mr; } inst_t;
  typedef struct packed { logic [1:0] a, b; logic st, fl; logic [31:0] sc, fc; } exp_t;

  exp_t        q[$];
  inst_t       hist[3];  // index = age: 0 in EX, 1 in MEM, 2 in WB
  logic [31:0] scnt, fcnt;
  int          checks = 0, errors = 0;
  logic        last_stall;

  function automatic logic [1:0] exp_sel(input logic [4:0] src);
    for (int k = 1; k <= 2; k++)
      if (hist[k].we && hist[k].rd != 0 && hist[k].rd == src)
        return (k == 1) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ut, input logic [4:0] rd, input logic rw,
                      input logic mr, input logic br, input logic r);
    exp_t  e;
    inst_t nw;
    @(posedge clk); #1;
    rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ut;
    id_rd = rd; id_regwrite = rw; id_memread = mr; ex_branch_taken = br;
    e.a  = exp_sel(hist[0].rs);
    e.b  = exp_sel(hist[0].rt);
    e.fl = br;
    e.st = v && hist[0].mr && hist[0].rd != 0 &&
           (hist[0].rd == rs || (ut && hist[0].rd == rt)) && !br;
    e.sc = scnt;
    e.fc = fcnt;
    q.push_back(e);
    last_stall = e.st;
    if (r) begin
      hist = '{default: '0};
      scnt = 0;
      fcnt = 0;
    end else begin
      scnt = scnt + 32'(e.st);
      fcnt = fcnt + 32'(e.fl);
      nw = '{rs: rs, rt: rt, rd: rd, we: rw, mr: mr};
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (v && !e.st && !e.fl) ? nw : '0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 5'($urandom), 5'($urandom), 1'b1, 5'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e.a));
        chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e.b));
        chk("stall",     32'(stall),     32'(e.st));
        chk("flush",     32'(flush),     32'(e.fl));
        chk("stall_cnt", stall_cnt,      e.sc);
        chk("flush_cnt", flush_cnt,      e.fc);
      end
    end
  end

  initial begin
    logic       v, ut, rw, mr, br, r;
    logic [4:0] rs, rt, rd;
    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    id_rd = '0; id_regwrite = 1'b0; id_memread = 1'b0; ex_branch_taken = 1'b0;
    hist = '{default: '0}; scnt = 0; fcnt = 0; last_stall = 1'b0;
    repeat (2) @(posedge clk);

    idle(2);                                            // reset state
    step(1, 1, 2, 1, 3, 1, 0, 0, 0);                    // add $3,$1,$2
    step(1, 3, 5, 1, 4, 1, 0, 0, 0);                    // sub $4,$3,$5
    idle(3);
    step(1, 1, 2, 1, 3, 1, 0, 0, 0);                    // add $3
    idle(1);                                            // nop
    step(1, 3, 3, 1, 6, 1, 0, 0, 0);                    // or $6,$3,$3 -> WB
    idle(3);
    step(1, 1, 2, 1, 3, 1, 0, 0, 0);                    // add $3
    step(1, 1, 1, 1, 3, 1, 0, 0, 0);                    // second writer of $3
    step(1, 3, 3, 1, 6, 1, 0, 0, 0);                    // MEM wins
    idle(3);
    step(1, 9, 0, 0, 8, 1, 1, 0, 0);                    // lw $8,0($9)
    step(1, 8, 1, 1, 10, 1, 0, 0, 0);                   // add $10,$8,$1 stalls
    step(1, 8, 1, 1, 10, 1, 0, 0, 0);                   // held copy proceeds
    idle(3);
    step(1, 1, 0, 0, 0, 1, 0, 0, 0);                    // addi $0
    step(1, 0, 0, 1, 2, 1, 0, 0, 0);                    // add $2,$0,$0
    idle(3);
    step(1, 9, 0, 0, 7, 1, 1, 0, 0);                    // lw $7
    step(1, 5, 7, 0, 4, 1, 0, 0, 0);                    // addi $4,$5,7: no stall
    idle(3);
    step(1, 9, 0, 0, 8, 1, 1, 0, 0);                    // lw $8
    step(1, 8, 1, 1, 10, 1, 0, 1, 0);                   // hazard + branch taken
    idle(3);
    step(1, 1, 2, 1, 5, 1, 0, 0, 0);                    // writer of $5
    step(1, 5, 5, 1, 6, 1, 0, 0, 0);                    // reader of $5
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);                    // reset mid-stream
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      if (!(last_stall && !br)) begin
        v  = ($urandom_range(0, 7) != 0);
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        ut = $urandom_range(0, 1) == 1;
        mr = ($urandom_range(0, 9) < 3);
        rw = mr || ($urandom_range(0, 9) < 8);
      end
      br = ($urandom_range(0, 99) < 8);
      r  = ($urandom_range(0, 99) < 1);
      step(v, rs, rt, ut, rd, rw, mr, br, r);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations unconsumed, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
